// File: rtl/node_sweeper_pkg.sv
// Shared constants and FSM state encoding for the node sweeper.
package node_sweep_pkg;
    localparam int          VEC_W     = 10;
    localparam int          SIG_W     = 16;
    localparam logic [15:0] MISR_POLY = 16'h1021;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_REPORT = 2'd2,
        ST_DONE   = 2'd3
    } state_e;
endpackage

// File: rtl/node_sweeper_if.sv
// Per-vector result channel from the sweeper to its consumer.
interface node_sweeper_if;
    import node_sweep_pkg::*;

    // valid/ready: a result transfers on a rising edge where res_valid and
    // res_ready are both high; while res_valid is high and res_ready is low,
    // res_vec and res_bit hold their values and res_valid stays high.
    logic             res_valid;
    logic             res_ready;
    logic [VEC_W-1:0] res_vec;
    logic             res_bit;

    modport master (output res_valid, res_vec, res_bit, input res_ready);
    modport slave  (input res_valid, res_vec, res_bit, output res_ready);
endinterface

// File: rtl/node_sweeper_misr.sv
// Serial-input MISR accumulating one captured bit per enabled cycle.
module node_sweep_misr
    import node_sweep_pkg::*;
#(
    parameter int WIDTH = SIG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             cap_bit,
    output logic [WIDTH-1:0] sig
);
    localparam logic [WIDTH-1:0] POLY = WIDTH'(MISR_POLY);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= ({sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0))
                   ^ {{(WIDTH-1){1'b0}}, cap_bit};
        end
    end
endmodule

// File: rtl/node_sweeper.sv
// Exhaustive 10-bit stimulus sweep of a node, capturing its output per vector.
module node_sweeper
    import node_sweep_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int VEC_W       = node_sweep_pkg::VEC_W,
    parameter int SIG_W       = node_sweep_pkg::SIG_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               node_out,
    output logic [1:0]         drv_in,
    output logic [1:0]         drv_in1,
    output logic [1:0]         drv_in2,
    output logic [1:0]         drv_in3,
    output logic [1:0]         drv_in4,
    node_sweeper_if.master     res,
    output logic [VEC_W:0]     ones_cnt,
    output logic [SIG_W-1:0]   signature,
    output logic               busy,
    output logic               done,
    output logic [1:0]         state_dbg
);
    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_DRIVE  = ST_DRIVE;
    localparam logic [1:0] S_REPORT = ST_REPORT;
    localparam logic [1:0] S_DONE   = ST_DONE;

    localparam logic [7:0]       HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_VEC  = '1;

    logic [1:0]       state;
    logic [VEC_W-1:0] idx;
    logic [7:0]       hold;
    logic             start_ok;
    logic             cap_en;
    logic             drv_active;

    assign start_ok   = start && (state == S_IDLE || state == S_DONE);
    assign cap_en     = (state == S_DRIVE) && (hold == HOLD_LAST);
    assign drv_active = (state == S_DRIVE) || (state == S_REPORT);
    assign state_dbg  = state;

    // Stimulus is only presented while a vector is in flight.
    assign drv_in  = drv_active ? idx[9:8] : 2'b00;
    assign drv_in1 = drv_active ? idx[7:6] : 2'b00;
    assign drv_in2 = drv_active ? idx[5:4] : 2'b00;
    assign drv_in3 = drv_active ? idx[3:2] : 2'b00;
    assign drv_in4 = drv_active ? idx[1:0] : 2'b00;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            idx           <= '0;
            hold          <= '0;
            ones_cnt      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            res.res_valid <= 1'b0;
            res.res_vec   <= '0;
            res.res_bit   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_DRIVE;
                        idx      <= '0;
                        hold     <= '0;
                        ones_cnt <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    if (hold == HOLD_LAST) begin
                        res.res_bit   <= node_out;
                        res.res_vec   <= idx;
                        res.res_valid <= 1'b1;
                        ones_cnt      <= ones_cnt + {{VEC_W{1'b0}}, node_out};
                        state         <= S_REPORT;
                    end else begin
                        hold <= hold + 8'd1;
                    end
                end
                S_REPORT: begin
                    if (res.res_ready) begin
                        res.res_valid <= 1'b0;
                        if (idx == LAST_VEC) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            hold  <= '0;
                            state <= S_DRIVE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    node_sweep_misr #(.WIDTH(SIG_W)) u_misr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start_ok),
        .en      (cap_en),
        .cap_bit (node_out),
        .sig     (signature)
    );
endmodule

// File: tb/tb_node_sweeper.sv
// Bench for node_sweeper: full sweeps against a reference model, stall, reset and restart.
module tb_node_sweeper;
    localparam int N_VEC = 1024;
    localparam int HOLD  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        node_out;
    logic [1:0]  drv_in, drv_in1, drv_in2, drv_in3, drv_in4;
    logic [10:0] ones_cnt;
    logic [15:0] signature;
    logic        busy, done;
    logic [1:0]  state_dbg;

    node_sweeper_if res_if();

    int   n_checks = 0;
    int   n_fail = 0;
    int   node_mode = 0;
    logic rnd_tab [N_VEC];
    logic [10:0] exp_q[$];

    always #5 clk = ~clk;

    // Node under test: 0 = stuck low, 1 = LSB of the vector, 2 = random truth table.
    assign node_out = (node_mode == 0) ? 1'b0 :
                      (node_mode == 1) ? drv_in4[0] :
                      rnd_tab[{drv_in, drv_in1, drv_in2, drv_in3, drv_in4}];

    node_sweeper #(.HOLD_CYCLES(HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .node_out  (node_out),
        .drv_in    (drv_in),
        .drv_in1   (drv_in1),
        .drv_in2   (drv_in2),
        .drv_in3   (drv_in3),
        .drv_in4   (drv_in4),
        .res       (res_if),
        .ones_cnt  (ones_cnt),
        .signature (signature),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    function automatic logic model_bit(input int mode, input int k);
        if (mode == 0) return 1'b0;
        if (mode == 1) return k[0];
        return rnd_tab[k];
    endfunction

    // Signature as polynomial arithmetic: multiply by x, reduce, add the new bit.
    function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic b);
        int v;
        v = int'(s) * 2;
        if (v >= 65536) v = (v - 65536) ^ 32'h1021;
        v = v ^ int'(b);
        return v[15:0];
    endfunction

    task automatic do_sweep(input string name, input int mode, input int rdy_pct,
                            input int len_exp, input int inject_at);
        int          cyc;
        int          exp_ones;
        logic [15:0] exp_sig;
        logic [10:0] e;
        logic [9:0]  lanes;
        logic        b;
        bit          fin;
        node_mode = mode;
        exp_q.delete();
        exp_ones = 0;
        exp_sig  = '0;
        for (int k = 0; k < N_VEC; k++) begin
            b = model_bit(mode, k);
            exp_q.push_back({10'(k), b});
            exp_ones += int'(b);
            exp_sig = misr_ref(exp_sig, b);
        end
        @(negedge clk);
        start = 1'b1;
        res_if.res_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || ones_cnt !== 11'd0 || signature !== 16'h0) begin
            n_fail++;
            $display("FAIL %s_start busy=%b done=%b ones=%0d sig=%h exp busy=1 done=0 ones=0 sig=0000",
                     name, busy, done, ones_cnt, signature);
        end
        cyc = 0;
        fin = 1'b0;
        while (!fin && cyc < 20000) begin
            @(negedge clk);
            start = 1'b0;
            res_if.res_ready = ($urandom_range(99) < rdy_pct);
            if (res_if.res_valid && res_if.res_ready) begin
                lanes = {drv_in, drv_in1, drv_in2, drv_in3, drv_in4};
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s_extra got vec=%0d exp no more results", name, res_if.res_vec);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if ({res_if.res_vec, res_if.res_bit} !== e) begin
                        n_fail++;
                        $display("FAIL %s_result got vec=%0d bit=%b exp vec=%0d bit=%b",
                                 name, res_if.res_vec, res_if.res_bit, e[10:1], e[0]);
                    end
                    n_checks++;
                    if (lanes !== e[10:1]) begin
                        n_fail++;
                        $display("FAIL %s_drv got %h exp %h", name, lanes, e[10:1]);
                    end
                    if (inject_at >= 0 && e[10:1] == 10'(inject_at)) start = 1'b1;
                end
            end
            @(posedge clk);
            cyc++;
            #1;
            fin = (done === 1'b1);
        end
        start = 1'b0;
        n_checks++;
        if (!fin) begin
            n_fail++;
            $display("FAIL %s_timeout got done=%b exp done=1 within 20000 cycles", name, done);
        end
        if (len_exp > 0) begin
            n_checks++;
            if (cyc != len_exp) begin
                n_fail++;
                $display("FAIL %s_length got %0d exp %0d", name, cyc, len_exp);
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing got %0d results left exp 0", name, exp_q.size());
        end
        n_checks++;
        if (ones_cnt !== 11'(exp_ones)) begin
            n_fail++;
            $display("FAIL %s_ones got %0d exp %0d", name, ones_cnt, exp_ones);
        end
        n_checks++;
        if (signature !== exp_sig) begin
            n_fail++;
            $display("FAIL %s_sig got %h exp %h", name, signature, exp_sig);
        end
        n_checks++;
        if (busy !== 1'b0 || res_if.res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_end got busy=%b valid=%b exp 0 0", name, busy, res_if.res_valid);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        res_if.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({drv_in, drv_in1, drv_in2, drv_in3, drv_in4} !== 10'd0 || res_if.res_valid !== 1'b0 ||
            res_if.res_vec !== 10'd0 || res_if.res_bit !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            ones_cnt !== 11'd0 || signature !== 16'h0 || state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL reset got drv=%h valid=%b vec=%0d busy=%b done=%b ones=%0d sig=%h st=%0d exp all 0",
                     {drv_in, drv_in1, drv_in2, drv_in3, drv_in4}, res_if.res_valid, res_if.res_vec,
                     busy, done, ones_cnt, signature, state_dbg);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_zero_sweep;
        do_sweep("zero", 0, 100, N_VEC * (HOLD + 1), -1);
    endtask

    task automatic test_lsb_sweep_with_restart_attempt;
        do_sweep("lsb", 1, 70, 0, 100);
    endtask

    task automatic test_random_restart_from_done;
        for (int k = 0; k < N_VEC; k++) rnd_tab[k] = 1'($urandom_range(1));
        do_sweep("rand", 2, 60, 0, -1);
    endtask

    task automatic test_stall;
        int cyc;
        node_mode = 1;
        @(negedge clk);
        start = 1'b1;
        res_if.res_ready = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (res_if.res_valid !== 1'b1 && cyc < 50) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        n_checks++;
        if (res_if.res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_first got valid=%b exp 1", res_if.res_valid);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if (res_if.res_valid !== 1'b1 || res_if.res_vec !== 10'd0 ||
                {drv_in, drv_in1, drv_in2, drv_in3, drv_in4} !== 10'd0) begin
                n_fail++;
                $display("FAIL stall_hold got valid=%b vec=%0d drv=%h exp 1 0 000",
                         res_if.res_valid, res_if.res_vec, {drv_in, drv_in1, drv_in2, drv_in3, drv_in4});
            end
        end
        @(negedge clk);
        res_if.res_ready = 1'b1;
        n_checks++;
        if (res_if.res_bit !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_bit got %b exp 0", res_if.res_bit);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (res_if.res_valid !== 1'b0 || {drv_in, drv_in1, drv_in2, drv_in3, drv_in4} !== 10'd1) begin
            n_fail++;
            $display("FAIL stall_release got valid=%b drv=%h exp 0 001",
                     res_if.res_valid, {drv_in, drv_in1, drv_in2, drv_in3, drv_in4});
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_sweep;
        int cyc;
        node_mode = 1;
        @(negedge clk);
        start = 1'b1;
        res_if.res_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!(res_if.res_valid === 1'b1 && res_if.res_vec === 10'd37) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (res_if.res_vec !== 10'd37) begin
            n_fail++;
            $display("FAIL rstmid_reach got vec=%0d exp 37", res_if.res_vec);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({drv_in, drv_in1, drv_in2, drv_in3, drv_in4} !== 10'd0 || res_if.res_valid !== 1'b0 ||
            res_if.res_vec !== 10'd0 || res_if.res_bit !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            ones_cnt !== 11'd0 || signature !== 16'h0 || state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL rstmid_clear got drv=%h valid=%b vec=%0d busy=%b ones=%0d sig=%h st=%0d exp all 0",
                     {drv_in, drv_in1, drv_in2, drv_in3, drv_in4}, res_if.res_valid, res_if.res_vec,
                     busy, ones_cnt, signature, state_dbg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (res_if.res_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_quiet got valid=%b busy=%b exp 0 0", res_if.res_valid, busy);
            end
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (res_if.res_valid !== 1'b1 && cyc < 50) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        n_checks++;
        if (res_if.res_valid !== 1'b1 || res_if.res_vec !== 10'd0) begin
            n_fail++;
            $display("FAIL rstmid_restart got valid=%b vec=%0d exp 1 0", res_if.res_valid, res_if.res_vec);
        end
    endtask

    initial begin
        res_if.res_ready = 1'b0;
        for (int k = 0; k < N_VEC; k++) rnd_tab[k] = 1'b0;
        test_reset();
        test_zero_sweep();
        test_lsb_sweep_with_restart_attempt();
        test_random_restart_from_done();
        test_stall();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/node_sweeper.md
NODE_SWEEPER -- requirements
Module: node_sweeper

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: cycles each input vector is driven before node_out is captured; legal range 2..255.
REQ-002 Parameter VEC_W, default 10: sweep vector width; fixed at 10 (five 2-bit lanes).
REQ-003 Parameter SIG_W, default 16: MISR signature width.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  single-cycle pulse; starts a sweep when the block is not busy.
REQ-007 node_out  input  1  output bit of the node under test.
REQ-008 drv_in  output  2  node lane 0 stimulus, vector bits [9:8].
REQ-009 drv_in1 / drv_in2 / drv_in3 / drv_in4  output  2 each  stimulus, vector bits [7:6] / [5:4] / [3:2] / [1:0].
REQ-010 res_valid  output  1  per-vector result available.
REQ-011 res_ready  input  1  consumer accepts the result.
REQ-012 res_vec  output  10  vector index of the current result.
REQ-013 res_bit  output  1  captured node_out for res_vec.
REQ-014 ones_cnt  output  11  running count of captured ones.
REQ-015 signature  output  16  running MISR over captured bits.
REQ-016 busy  output  1  high from sweep start until DONE entry.
REQ-017 done  output  1  high in DONE.

Function
REQ-018 FSM states: IDLE, DRIVE, REPORT, DONE.
REQ-019 IDLE, start=1 -> DRIVE: vector index i=0, hold counter=0, ones_cnt=0, signature=0, busy=1.
REQ-020 DRIVE: drv_* = lane slices of i, stable for the whole state; hold counter increments each cycle.
REQ-021 DRIVE at hold counter = HOLD_CYCLES-1: node_out captured into res_bit, res_vec=i, res_valid=1, ones_cnt += node_out, MISR updated; next state REPORT.
REQ-022 MISR update: sig <= ({sig[14:0],1'b0} XOR (sig[15] ? 16'h1021 : 0)) XOR {15'b0, captured bit}.
REQ-023 REPORT: res_valid=1; res_vec, res_bit and drv_* held stable until res_valid && res_ready.
REQ-024 REPORT handshake with i<1023: res_valid=0, i=i+1, hold counter=0, next state DRIVE; drv_* show the new vector in the first DRIVE cycle.
REQ-025 REPORT handshake with i=1023: res_valid=0, busy=0, done=1, next state DONE; no wrap to 0.
REQ-026 DONE: ones_cnt and signature held; start=1 -> behaves as in IDLE (REQ-019), done=0.
REQ-027 start while busy=1 is ignored; no restart, no counter disturbance.
REQ-028 With res_ready tied high, a sweep takes exactly 1024*(HOLD_CYCLES+1) cycles from the start pulse to done=1.
REQ-029 ones_cnt never saturates; maximum value 1024 fits in 11 bits.

Reset
REQ-030 rst_n=0 at a clock edge: state=IDLE; i, hold counter, ones_cnt, signature=0; all outputs (drv_*, res_valid, res_vec, res_bit, busy, done)=0.
REQ-031 Reset mid-sweep aborts without emitting a further result; the next start sweeps again from vector 0.

Structure
REQ-032 Package node_sweep_pkg holds VEC_W, SIG_W, the MISR polynomial 16'h1021 and the FSM state enum.
REQ-033 Sub-module node_sweep_misr (inputs clk, rst_n, clr, en, bit; output sig) implements REQ-022; instantiated once.

Verification
REQ-034 node_out tied 0, res_ready=1, HOLD_CYCLES=4, start pulse -> done=1 exactly 5120 cycles later, ones_cnt=0, signature=16'h0000.
REQ-035 node_out modelled as drv_in4[0] -> ones_cnt=512; res_bit matches res_vec[0] for all 1024 results, which arrive in order 0..1023.
REQ-036 res_ready held low after the first capture for 20 cycles -> res_valid stays 1, res_vec=0, drv_* all 0, no index advance; result accepted on release.
REQ-037 rst_n=0 for one cycle while res_vec=37 -> next cycle all outputs 0, state IDLE; a new start produces a first result with res_vec=0.
REQ-038 Second start pulse at vector 100 mid-sweep -> ignored; sweep finishes normally; a start in DONE restarts with done=0 and ones_cnt cleared.
